e203_exu_wbck_arb: RTL



---
 rtl/e203_exu_wbck_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/e203_exu_wbck_arb.sv
// ---------------------------------------------------------------------------
// e203_exu_wbck_arb
//
// Write-side front end of the general-purpose register file. Single-cycle ALU
// results go straight to the regfile write port; long-pipe (LSU/MULDIV)
// results are buffered in a small in-order FIFO and drained through the same
// port. The FIFO normally has priority, but once the ALU has waited
// STARVE_MAX cycles it is granted for one cycle.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   alu_wbck_i_*              ALU result handshake {valid, ready, wdat, rdidx}
//   longp_wbck_i_*            long-pipe result handshake {valid, ready, wdat, rdidx}
//   rf_wbck_o_*               regfile write port {ena, wdat, rdidx}
//   longp_pend_o              FIFO non-empty, used by dispatch for hazard stall
// ---------------------------------------------------------------------------
module e203_exu_wbck_arb #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int LFIFO_DEPTH = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   alu_wbck_i_valid,
  output logic                   alu_wbck_i_ready,
  input  logic [XLEN-1:0]        alu_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,

  input  logic                   longp_wbck_i_valid,
  output logic                   longp_wbck_i_ready,
  input  logic [XLEN-1:0]        longp_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] longp_wbck_i_rdidx,

  output logic                   rf_wbck_o_ena,
  output logic [XLEN-1:0]        rf_wbck_o_wdat,
  output logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,

  output logic                   longp_pend_o
);

  localparam int PTR_W = $clog2(LFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(LFIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO_C = PTR_W'(0);
  localparam logic [STV_W-1:0] STV_MAX_C  = STV_W'(STARVE_MAX);
  localparam logic [STV_W-1:0] STV_ONE_C  = STV_W'(1);
  localparam logic [STV_W-1:0] STV_ZERO_C = STV_W'(0);
  localparam logic [RFIDX_WIDTH-1:0] IDX_X0_C = RFIDX_WIDTH'(0);

  // FIFO storage (data words are not reset; validity is tracked by cnt_q)
  logic [XLEN-1:0]        fifo_dat_q [LFIFO_DEPTH];
  logic [RFIDX_WIDTH-1:0] fifo_idx_q [LFIFO_DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic                   fifo_nempty_s;
  logic                   fifo_nfull_s;
  logic                   alu_starved_s;
  logic                   fifo_sel_s;
  logic                   enq_s;
  logic                   deq_s;
  logic [RFIDX_WIDTH-1:0] sel_idx_s;
  logic [XLEN-1:0]        sel_dat_s;

  // Grant selection and output mux
  always_comb begin
    fifo_nempty_s = (cnt_q != CNT_ZERO_C);
    fifo_nfull_s  = (cnt_q < DEPTH_C);
    // ALU wins only after it has been passed over STARVE_MAX times in a row
    alu_starved_s = alu_wbck_i_valid & (starve_q == STV_MAX_C);
    fifo_sel_s    = fifo_nempty_s & ~alu_starved_s;
    // Ready is based on the registered count only, never on a same-cycle dequeue
    enq_s         = longp_wbck_i_valid & fifo_nfull_s;
    deq_s         = fifo_sel_s;

    if (fifo_sel_s) begin
      sel_idx_s = fifo_idx_q[rptr_q];
      sel_dat_s = fifo_dat_q[rptr_q];
    end else begin
      sel_idx_s = alu_wbck_i_rdidx;
      sel_dat_s = alu_wbck_i_wdat;
    end

    alu_wbck_i_ready   = ~rst & ~fifo_sel_s;
    longp_wbck_i_ready = ~rst & fifo_nfull_s;
    // x0 writes still complete the handshake/dequeue but never reach the regfile
    rf_wbck_o_ena      = ~rst & (fifo_sel_s | alu_wbck_i_valid) & (sel_idx_s != IDX_X0_C);
    rf_wbck_o_wdat     = sel_dat_s;
    rf_wbck_o_rdidx    = sel_idx_s;
    longp_pend_o       = fifo_nempty_s;
  end

  // Next-state for pointers, occupancy count and starvation counter
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;

    if (enq_s) begin
      wptr_d = wptr_q + PTR_ONE_C;  // power-of-two depth: natural wrap
    end else begin
      wptr_d = wptr_q;
    end

    if (deq_s) begin
      rptr_d = rptr_q + PTR_ONE_C;
    end else begin
      rptr_d = rptr_q;
    end

    case ({enq_s, deq_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE_C;
      2'b01:   cnt_d = cnt_q - CNT_ONE_C;
      default: cnt_d = cnt_q;
    endcase

    // Count only cycles where a valid ALU result was passed over for the FIFO
    if (alu_wbck_i_valid & fifo_sel_s) begin
      if (starve_q == STV_MAX_C) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + STV_ONE_C;
      end
    end else begin
      starve_d = STV_ZERO_C;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= PTR_ZERO_C;
      rptr_q   <= PTR_ZERO_C;
      cnt_q    <= CNT_ZERO_C;
      starve_q <= STV_ZERO_C;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // FIFO entry write on enqueue
  always_ff @(posedge clk) begin
    if (enq_s & ~rst) begin
      fifo_dat_q[wptr_q] <= longp_wbck_i_wdat;
      fifo_idx_q[wptr_q] <= longp_wbck_i_rdidx;
    end else begin
      fifo_dat_q[wptr_q] <= fifo_dat_q[wptr_q];
      fifo_idx_q[wptr_q] <= fifo_idx_q[wptr_q];
    end
  end

endmodule
